// File: rtl/mcast_cfg_sequencer_if.sv
// Interface bundling the weight stream from the host/DMA with the shared
// MultiCaster row bus. The master modport is the sequencer side. The slave
// modport is the side that feeds weights and models the MultiCaster rows.
interface mcast_cfg_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int NUM_ROW    = 4
);
    localparam int TW = $clog2(NUM_COL) + 1;

    // Weight stream (host/DMA -> sequencer)
    logic                  wgt_valid;
    logic [DATA_WIDTH-1:0] wgt_data;
    logic                  wgt_ready;

    // MultiCaster row bus (sequencer -> rows)
    logic [NUM_ROW-1:0]    mc_sel;
    logic                  mc_flush_kernel;
    logic [7:0]            mc_kernel_size;
    logic [DATA_WIDTH-1:0] mc_fltr_data;
    logic                  mc_flush_tag;
    logic [TW-1:0]         mc_tag;
    logic                  pe_itr_ready;

    // Per-row status (rows -> sequencer)
    logic [NUM_ROW-1:0]    mc_kernel_busy;
    logic [NUM_ROW-1:0]    mc_tag_lock;
    logic [NUM_ROW-1:0]    mc_valid;

    modport master (
        input  wgt_valid, wgt_data,
        output wgt_ready,
        output mc_sel, mc_flush_kernel, mc_kernel_size, mc_fltr_data,
        output mc_flush_tag, mc_tag, pe_itr_ready,
        input  mc_kernel_busy, mc_tag_lock, mc_valid
    );

    modport slave (
        output wgt_valid, wgt_data,
        input  wgt_ready,
        input  mc_sel, mc_flush_kernel, mc_kernel_size, mc_fltr_data,
        input  mc_flush_tag, mc_tag, pe_itr_ready,
        output mc_kernel_busy, mc_tag_lock, mc_valid
    );
endinterface

// File: rtl/mcast_cfg_sequencer.sv
// mcast_cfg_sequencer: configures NUM_ROW MultiCaster rows over one shared
// bus. For each row it flushes the kernel size, streams the filter weights,
// waits for the weight buffer, flushes the column tag and waits for the tag
// lock. It then raises pe_itr_ready until every row reports valid.
// Optional feature: define MCSEQ_TIMEOUT_EN to add a 16-bit watchdog on
// WAIT_K, WAIT_T and RUN. The watchdog raises cfg_err and aborts the sequence.
module mcast_cfg_sequencer #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  NUM_COL     = 4,
    parameter int  NUM_ROW     = 4,
    parameter int  MAX_KSIZE   = 16,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int TW          = $clog2(NUM_COL) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_start,
    input  logic          cfg_abort,
    input  logic [7:0]    cfg_kernel_size,
    input  logic [TW-1:0] cfg_tag_base,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_err,
    mcast_cfg_sequencer_if.master bus
);
    localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROW - 1);

    // The kernel size port is 8 bits wide. The watchdog counter is 16 bits wide.
    if (MAX_KSIZE < 1 || MAX_KSIZE > 255) begin : g_bad_ksize
        $error("MAX_KSIZE must lie in 1..255");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_FLUSH_K, ST_LOAD_W, ST_WAIT_K,
        ST_FLUSH_T, ST_WAIT_T, ST_RUN, ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            ksize_q, ksize_d;
    logic [TW-1:0]         tag_base_q, tag_base_d;
    logic                  cfg_busy_q, cfg_busy_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  wgt_ready_q, wgt_ready_d;
    logic [NUM_ROW-1:0]    mc_sel_q, mc_sel_d;
    logic                  flush_k_q, flush_k_d;
    logic [DATA_WIDTH-1:0] fltr_q, fltr_d;
    logic                  flush_t_q, flush_t_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic                  pe_rdy_q, pe_rdy_d;
`ifdef MCSEQ_TIMEOUT_EN
    localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0]           timer_q, timer_d;
`endif

    logic beat_fire;
    logic size_bad;

    assign beat_fire = bus.wgt_valid & wgt_ready_q;
    assign size_bad  = (cfg_kernel_size == 8'd0) || (int'(cfg_kernel_size) > MAX_KSIZE);

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        // NOTE: each signal assigned in this block gets a default value first.
        // No path through the case statement can then leave a signal unassigned,
        // so synthesis infers no latch.
        state_d     = state_q;
        row_d       = row_q;
        beat_d      = beat_q;
        ksize_d     = ksize_q;
        tag_base_d  = tag_base_q;
        cfg_done_d  = 1'b0;
        cfg_err_d   = 1'b0;
        wgt_ready_d = 1'b0;
        flush_k_d   = 1'b0;
        flush_t_d   = 1'b0;
        pe_rdy_d    = 1'b0;
        fltr_d      = '0;
        tag_d       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    tag_base_d = cfg_tag_base;
                    if (size_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        // Only a legal size reaches mc_kernel_size.
                        ksize_d   = cfg_kernel_size;
                        row_d     = '0;
                        beat_d    = '0;
                        flush_k_d = 1'b1;
                        state_d   = ST_FLUSH_K;
                    end
                end
            end
            ST_FLUSH_K: begin
                wgt_ready_d = 1'b1;
                state_d     = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                wgt_ready_d = 1'b1;
                if (beat_fire) begin
                    fltr_d = bus.wgt_data;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == ksize_q - 8'd1) begin
                        wgt_ready_d = 1'b0;
                        state_d     = ST_WAIT_K;
                    end
                end
            end
            ST_WAIT_K: begin
                // The first sample is taken one cycle after entry. By then the
                // row has seen its last weight and can report busy.
                if (!bus.mc_kernel_busy[row_q]) begin
                    flush_t_d = 1'b1;
                    tag_d     = tag_base_q + TW'(row_q);
                    state_d   = ST_FLUSH_T;
                end
            end
            ST_FLUSH_T: begin
                state_d = ST_WAIT_T;
            end
            ST_WAIT_T: begin
                if (bus.mc_tag_lock[row_q]) begin
                    if (row_q == LAST_ROW) begin
                        pe_rdy_d = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        row_d     = row_q + RW'(1);
                        beat_d    = '0;
                        flush_k_d = 1'b1;
                        state_d   = ST_FLUSH_K;
                    end
                end
            end
            ST_RUN: begin
                if (&bus.mc_valid) begin
                    cfg_done_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    pe_rdy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MCSEQ_TIMEOUT_EN
        // The watchdog counts only while a wait state holds.
        // It restarts on every state change.
        timer_d = '0;
        if ((state_d == state_q) &&
            (state_q == ST_WAIT_K || state_q == ST_WAIT_T || state_q == ST_RUN)) begin
            if (timer_q == TIMER_LIMIT) begin
                state_d   = ST_IDLE;
                row_d     = '0;
                beat_d    = '0;
                pe_rdy_d  = 1'b0;
                cfg_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end
`endif

        // Abort overrides every transition. This includes a start seen in the
        // same cycle and a weight beat arriving in the same cycle.
        if (cfg_abort) begin
            state_d     = ST_IDLE;
            row_d       = '0;
            beat_d      = '0;
            cfg_done_d  = 1'b0;
            cfg_err_d   = 1'b0;
            wgt_ready_d = 1'b0;
            flush_k_d   = 1'b0;
            flush_t_d   = 1'b0;
            pe_rdy_d    = 1'b0;
            fltr_d      = '0;
            tag_d       = '0;
`ifdef MCSEQ_TIMEOUT_EN
            timer_d     = '0;
`endif
        end

        cfg_busy_d = (state_d != ST_IDLE);
        mc_sel_d   = '0;
        if (state_d inside {ST_FLUSH_K, ST_LOAD_W, ST_WAIT_K, ST_FLUSH_T, ST_WAIT_T}) begin
            mc_sel_d = NUM_ROW'(1) << row_d;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses only non-blocking assignments. Every flop
        // then samples values from before the clock edge, whatever the
        // statement order.
        if (!rstn) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            beat_q      <= '0;
            ksize_q     <= '0;
            tag_base_q  <= '0;
            cfg_busy_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            wgt_ready_q <= 1'b0;
            mc_sel_q    <= '0;
            flush_k_q   <= 1'b0;
            fltr_q      <= '0;
            flush_t_q   <= 1'b0;
            tag_q       <= '0;
            pe_rdy_q    <= 1'b0;
`ifdef MCSEQ_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            ksize_q     <= ksize_d;
            tag_base_q  <= tag_base_d;
            cfg_busy_q  <= cfg_busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            wgt_ready_q <= wgt_ready_d;
            mc_sel_q    <= mc_sel_d;
            flush_k_q   <= flush_k_d;
            fltr_q      <= fltr_d;
            flush_t_q   <= flush_t_d;
            tag_q       <= tag_d;
            pe_rdy_q    <= pe_rdy_d;
`ifdef MCSEQ_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign cfg_busy            = cfg_busy_q;
    assign cfg_done            = cfg_done_q;
    assign cfg_err             = cfg_err_q;
    assign bus.wgt_ready       = wgt_ready_q;
    assign bus.mc_sel          = mc_sel_q;
    assign bus.mc_flush_kernel = flush_k_q;
    assign bus.mc_kernel_size  = ksize_q;
    assign bus.mc_fltr_data    = fltr_q;
    assign bus.mc_flush_tag    = flush_t_q;
    assign bus.mc_tag          = tag_q;
    assign bus.pe_itr_ready    = pe_rdy_q;
endmodule

// File: doc/mcast_cfg_sequencer.md
Name: mcast_cfg_sequencer

Overview:
- Configures and launches an array of NUM_ROW MultiCaster instances sharing one weight/config bus.
- Per row, in order: flush kernel size, stream that many filter weights, wait for the weight buffer to settle, flush the column tag, wait for the tag lock.
- After all rows are configured, it asserts PE_ITR_READY to the array and waits until every row reports VALID.
- Sits between the host/DMA configuration port and the MultiCaster row bus.

Parameters:
- DATA_WIDTH, 16, weight word width
- NUM_COL, 4, columns per row; tag width TW = $clog2(NUM_COL)+1
- NUM_ROW, 4, number of MultiCaster rows sequenced
- MAX_KSIZE, 16, largest legal kernel_size (weight buffer depth)
- TIMEOUT_CYC, 1024, watchdog limit; only used with MCSEQ_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_abort  in  1  synchronous abort to IDLE
- cfg_kernel_size  in  8  weights per row
- cfg_tag_base  in  TW  tag for row 0; row r gets cfg_tag_base+r, modulo 2^TW
- cfg_busy  out  1  high in any state except IDLE
- cfg_done  out  1  one-cycle pulse at sequence completion
- cfg_err  out  1  one-cycle pulse on an illegal size or a timeout
- wgt_valid  in  1  weight stream valid
- wgt_data  in  DATA_WIDTH  weight stream data
- wgt_ready  out  1  weight stream ready
- mc_sel  out  NUM_ROW  one-hot row select
- mc_flush_kernel  out  1  kernel_size load strobe
- mc_kernel_size  out  8  latched kernel size
- mc_fltr_data  out  DATA_WIDTH  weight to the selected row
- mc_flush_tag  out  1  tag load strobe
- mc_tag  out  TW  tag for the selected row
- mc_kernel_busy  in  NUM_ROW  per-row weight buffer busy
- mc_tag_lock  in  NUM_ROW  per-row tag locked
- pe_itr_ready  out  1  broadcast PE_ITR_READY
- mc_valid  in  NUM_ROW  per-row calculation done

Behaviour:
- Reset: all outputs 0; state IDLE; row, beat and timer counters 0.
- All outputs are registered. mc_sel is 0 in IDLE/RUN/DONE and onehot(row) otherwise.
- IDLE: on cfg_start, latch cfg_kernel_size and cfg_tag_base.
  - If size==0 or size>MAX_KSIZE: cfg_err=1 next cycle, stay IDLE.
  - Otherwise row=0 and go to FLUSH_K.
- FLUSH_K: exactly one cycle, mc_flush_kernel=1 with mc_kernel_size valid; go to LOAD_W.
- LOAD_W: wgt_ready=1.
  - Each wgt_valid&wgt_ready beat registers wgt_data onto mc_fltr_data for exactly one cycle and increments beat.
  - The beat equal to size-1 deasserts wgt_ready in the following cycle and moves to WAIT_K.
  - wgt_valid gaps stall without error.
- WAIT_K: wait for mc_kernel_busy[row]==0, sampled at least one cycle after entry; go to FLUSH_T.
- FLUSH_T: one cycle, mc_flush_tag=1, mc_tag=cfg_tag_base+row (wraps at 2^TW); go to WAIT_T.
- WAIT_T: wait for mc_tag_lock[row]==1.
  - If row==NUM_ROW-1, go to RUN.
  - Otherwise row++, beat=0, go to FLUSH_K.
- RUN: pe_itr_ready=1; wait for &mc_valid; go to DONE, dropping pe_itr_ready.
- DONE: cfg_done=1 for one cycle; go to IDLE.
- Boundary conditions:
  - cfg_start while busy is ignored.
  - cfg_abort has priority over every transition: next cycle IDLE, all strobes/ready 0, counters cleared, no cfg_done.
  - cfg_abort and cfg_start together in IDLE: abort wins, no start.
  - Reset mid-sequence returns to the reset state immediately.
  - A weight beat coinciding with abort is dropped.
- Latency (NUM_ROW=1, size=K, no stalls, busy/lock already satisfied): cfg_start to cfg_done = K+6 cycles.

Optional Feature:
- MCSEQ_TIMEOUT_EN defined:
  - A 16-bit timer runs in WAIT_K, WAIT_T and RUN, and clears on every state change.
  - Reaching TIMEOUT_CYC pulses cfg_err and returns to IDLE as for an abort.
- Undefined: no timer logic; those states wait indefinitely and cfg_err flags only an illegal size.

Test Plan:
- NUM_ROW=4, size=3, tag_base=2, ideal slave -> 4 flush_kernel pulses, 12 weight beats in order, mc_tag 2,3,4,5, one pe_itr_ready window, one cfg_done.
- size=0, then size=17 -> cfg_err pulse each, cfg_busy never rises, no mc_* strobes.
- tag_base=7 (TW=3), NUM_ROW=4 -> mc_tag 7,0,1,2 (wrap).
- wgt_valid toggling 1/0, size=5 -> exactly 5 beats accepted, mc_fltr_data matches the sent sequence, WAIT_K entered after the 5th beat.
- cfg_abort in LOAD_W after 2 beats -> IDLE next cycle, wgt_ready=0, no cfg_done; a following clean start completes normally.
- With MCSEQ_TIMEOUT_EN and TIMEOUT_CYC=20, mc_tag_lock held 0 -> cfg_err at 20 cycles in WAIT_T, then IDLE; without the macro, still waiting at cycle 100.
